// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back unit: register-file geometry, the
// hard-wired zero register and the queued result entry type.
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// In-order result queue for the write-back unit. It holds the storage,
// pointers and occupancy count. All entries are exposed together with a
// per-entry valid vector and the read pointer, so the parent can forward
// values oldest to youngest.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears pointers/count)
//   i_push, i_entry enqueue i_entry at the tail (ignored when full)
//   i_pop           dequeue the head (ignored when empty)
//   o_head          entry at the read pointer
//   o_entries       raw storage, indexed by slot
//   o_valid         per-slot occupancy
//   o_rptr          read pointer (slot of the oldest entry)
//   o_full, o_empty occupancy flags
// ---------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  wb_entry_t        i_entry,
   input  logic             i_pop,
   output wb_entry_t        o_head,
   output wb_entry_t        o_entries [DEPTH],
   output logic [DEPTH-1:0] o_valid,
   output logic [PTR_W-1:0] o_rptr,
   output logic             o_full,
   output logic             o_empty
);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is meaningful.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_entry;
   end

   // A slot is live when its age (distance from the head) is below count.
   always_comb begin
      logic [PTR_W-1:0] w_age;
      w_age   = '0;
      o_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_age      = PTR_W'(i) - r_rptr;
         o_valid[i] = ({1'b0, w_age} < r_count);
      end
   end

   assign o_entries = r_mem;
   assign o_head    = r_mem[r_rptr];
   assign o_rptr    = r_rptr;

endmodule

// File: rtl/wb_write_unit.sv
// ---------------------------------------------------------------------------
// wb_write_unit
// Sole writer of the 16x32 register file. It accepts completed results over
// a valid/ready handshake and drops non-writing results and writes to r0.
// Everything else is queued in order, and the queue head drives the
// register-file write port at one write per cycle. Operand readers can see
// not-yet-retired values through two forwarding ports (youngest match wins).
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   res_valid/res_ready      result handshake (ready from registered state only)
//   res_rd/res_data/res_is_wb result destination, value, write-back flag
//   wr_hold                  write port busy; head is held
//   rd/writeData/isWb        register-file write port
//   q_rs1/q_rs2              operand addresses being read
//   fwd1_*/fwd2_*            forward hit flag and data (0 on miss)
//   wb_pending               queue non-empty
// ---------------------------------------------------------------------------
module wb_write_unit
   import wb_pkg::wb_entry_t, wb_pkg::ZERO_REG;
#(
   parameter  int DEPTH  = 2,
   parameter  int ADDR_W = wb_pkg::ADDR_W,
   parameter  int DATA_W = wb_pkg::DATA_W,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [ADDR_W-1:0] res_rd,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_is_wb,
   input  logic              wr_hold,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] writeData,
   output logic              isWb,
   input  logic [ADDR_W-1:0] q_rs1,
   input  logic [ADDR_W-1:0] q_rs2,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic [DATA_W-1:0] fwd2_data,
   output logic              wb_pending
);

   wb_entry_t        w_entries [DEPTH];
   wb_entry_t        w_head;
   wb_entry_t        w_new;
   logic [DEPTH-1:0] w_valid;
   logic [PTR_W-1:0] w_rptr;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // Ready looks only at reset and occupancy, so a full queue never accepts
   // even when the head retires in the same cycle.
   assign res_ready = !reset && !w_full;

   // Non-writing results and r0 writes complete the handshake but use no slot.
   assign w_push = res_valid && res_ready && res_is_wb && (res_rd != ZERO_REG);
   assign w_new  = '{rd: res_rd, data: res_data};

   // Reset masks the write port so entries discarded by reset never retire.
   assign w_pop  = !reset && !w_empty && !wr_hold;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push),
      .i_entry   (w_new),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_entries (w_entries),
      .o_valid   (w_valid),
      .o_rptr    (w_rptr),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign isWb       = w_pop;
   assign rd         = w_pop ? w_head.rd   : '0;
   assign writeData  = w_pop ? w_head.data : '0;
   assign wb_pending = !reset && !w_empty;

   // Walk from oldest to youngest; a later match overrides an earlier one,
   // leaving the youngest value on each port.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      w_idx     = '0;
      fwd1_hit  = 1'b0;
      fwd2_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = w_rptr + PTR_W'(k);
         if (!reset && w_valid[w_idx]) begin
            if ((q_rs1 != ZERO_REG) && (w_entries[w_idx].rd == q_rs1)) begin
               fwd1_hit  = 1'b1;
               fwd1_data = w_entries[w_idx].data;
            end
            if ((q_rs2 != ZERO_REG) && (w_entries[w_idx].rd == q_rs2)) begin
               fwd2_hit  = 1'b1;
               fwd2_data = w_entries[w_idx].data;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_write_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_write_unit
// Bench for wb_write_unit. The reference model is a plain queue of
// {rd, data} records that is updated once per clock edge from the
// handshake rules. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_wb_write_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_rd;
   logic [31:0] res_data;
   logic        res_is_wb;
   logic        wr_hold;
   logic [3:0]  rd;
   logic [31:0] writeData;
   logic        isWb;
   logic [3:0]  q_rs1;
   logic [3:0]  q_rs2;
   logic        fwd1_hit;
   logic        fwd2_hit;
   logic [31:0] fwd1_data;
   logic [31:0] fwd2_data;
   logic        wb_pending;

   wb_write_unit #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_rd     (res_rd),
      .res_data   (res_data),
      .res_is_wb  (res_is_wb),
      .wr_hold    (wr_hold),
      .rd         (rd),
      .writeData  (writeData),
      .isWb       (isWb),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .fwd1_hit   (fwd1_hit),
      .fwd2_hit   (fwd2_hit),
      .fwd1_data  (fwd1_data),
      .fwd2_data  (fwd2_data),
      .wb_pending (wb_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Youngest queued value for an operand address.
   function automatic void model_fwd(input logic [3:0] q, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (!reset && q != 4'd0) begin
         foreach (mq[i]) begin
            if (mq[i].rd == q) begin
               hit = 1'b1;
               d   = mq[i].data;
            end
         end
      end
   endfunction

   task automatic drive(input logic v, input logic [3:0] r, input logic [31:0] d,
                        input logic wb, input logic hold, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic rst);
      res_valid = v;
      res_rd    = r;
      res_data  = d;
      res_is_wb = wb;
      wr_hold   = hold;
      q_rs1     = rs1;
      q_rs2     = rs2;
      reset     = rst;
      #2;
   endtask

   // Compare every output against the model, then advance one clock edge.
   task automatic tick();
      logic        m_rdy;
      logic        m_wb;
      logic [3:0]  m_rd;
      logic [31:0] m_wd;
      logic        h1;
      logic        h2;
      logic [31:0] d1;
      logic [31:0] d2;
      m_rdy = !reset && (mq.size() < DEPTH);
      m_wb  = !reset && (mq.size() > 0) && !wr_hold;
      m_rd  = m_wb ? mq[0].rd   : 4'd0;
      m_wd  = m_wb ? mq[0].data : 32'd0;
      model_fwd(q_rs1, h1, d1);
      model_fwd(q_rs2, h2, d2);
      chk("res_ready",  64'(res_ready),  64'(m_rdy));
      chk("isWb",       64'(isWb),       64'(m_wb));
      chk("rd",         64'(rd),         64'(m_rd));
      chk("writeData",  64'(writeData),  64'(m_wd));
      chk("wb_pending", 64'(wb_pending), 64'(!reset && mq.size() > 0));
      chk("fwd1_hit",   64'(fwd1_hit),   64'(h1));
      chk("fwd1_data",  64'(fwd1_data),  64'(d1));
      chk("fwd2_hit",   64'(fwd2_hit),   64'(h2));
      chk("fwd2_data",  64'(fwd2_data),  64'(d2));
      @(posedge clk);
      if (reset) begin
         mq.delete();
      end else begin
         if (m_wb) void'(mq.pop_front());
         if (res_valid && m_rdy && res_is_wb && res_rd != 4'd0)
            mq.push_back('{rd: res_rd, data: res_data});
      end
      #1;
   endtask

   initial begin
      // Reset held two cycles while a result is offered.
      drive(1, 4'd5, 32'h1111, 1, 0, 0, 0, 1);
      chk("rst_ready", 64'(res_ready), 64'd0);
      chk("rst_isWb",  64'(isWb), 64'd0);
      tick();
      drive(1, 4'd5, 32'h1111, 1, 0, 0, 0, 1);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
      chk("post_rst_ready",   64'(res_ready), 64'd1);
      chk("post_rst_pending", 64'(wb_pending), 64'd0);
      tick();

      // Single write: visible on the write port one cycle after acceptance.
      drive(1, 4'd5, 32'hDEADBEEF, 1, 0, 0, 0, 0);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
      chk("single_isWb", 64'(isWb), 64'd1);
      chk("single_rd",   64'(rd), 64'd5);
      chk("single_data", 64'(writeData), 64'hDEADBEEF);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
      chk("single_done", 64'(isWb), 64'd0);
      tick();

      // Filter: r0 write and non-writing result are consumed silently.
      drive(1, 4'd0, 32'h1234, 1, 0, 0, 0, 0);
      tick();
      drive(1, 4'd7, 32'h5678, 0, 0, 0, 0, 0);
      chk("filt_isWb0",    64'(isWb), 64'd0);
      chk("filt_pending0", 64'(wb_pending), 64'd0);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
      chk("filt_isWb1",    64'(isWb), 64'd0);
      chk("filt_pending1", 64'(wb_pending), 64'd0);
      tick();

      // Backpressure: two accepted under hold, third waits for room.
      drive(1, 4'd1, 32'h101, 1, 1, 0, 0, 0);
      tick();
      drive(1, 4'd2, 32'h102, 1, 1, 0, 0, 0);
      tick();
      drive(1, 4'd3, 32'h103, 1, 1, 0, 0, 0);
      chk("bp_full_ready", 64'(res_ready), 64'd0);
      tick();
      drive(1, 4'd3, 32'h103, 1, 0, 0, 0, 0);
      chk("bp_w1_rd",    64'(rd), 64'd1);
      chk("bp_w1_ready", 64'(res_ready), 64'd0);
      tick();
      drive(1, 4'd3, 32'h103, 1, 0, 0, 0, 0);
      chk("bp_w2_rd",    64'(rd), 64'd2);
      chk("bp_w2_ready", 64'(res_ready), 64'd1);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
      chk("bp_w3_rd",   64'(rd), 64'd3);
      chk("bp_w3_isWb", 64'(isWb), 64'd1);
      tick();

      // Forwarding: youngest of two writes to r3 wins; r0 never hits.
      drive(1, 4'd3, 32'hA, 1, 1, 4'd3, 0, 0);
      chk("fwd_same_cycle", 64'(fwd1_hit), 64'd0);
      tick();
      drive(1, 4'd3, 32'hB, 1, 1, 4'd3, 0, 0);
      chk("fwd_one_data", 64'(fwd1_data), 64'hA);
      tick();
      drive(0, 4'd0, 32'h0, 0, 1, 4'd3, 4'd0, 0);
      chk("fwd1_hit_y",  64'(fwd1_hit), 64'd1);
      chk("fwd1_data_y", 64'(fwd1_data), 64'hB);
      chk("fwd2_hit_0",  64'(fwd2_hit), 64'd0);
      chk("fwd2_data_0", 64'(fwd2_data), 64'd0);
      tick();

      // Mid-operation reset discards both queued entries.
      drive(0, 4'd0, 32'h0, 0, 0, 4'd3, 0, 1);
      chk("mrst_isWb", 64'(isWb), 64'd0);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 4'd3, 0, 0);
      chk("mrst_pending", 64'(wb_pending), 64'd0);
      chk("mrst_isWb2",   64'(isWb), 64'd0);
      chk("mrst_fwd",     64'(fwd1_hit), 64'd0);
      tick();
      drive(0, 4'd0, 32'h0, 0, 0, 0, 0, 0);
      tick();

      // Random traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 9) < 7,
               4'($urandom_range(0, 7)),
               $urandom,
               $urandom_range(0, 9) < 8,
               $urandom_range(0, 9) < 3,
               4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)),
               $urandom_range(0, 59) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
